sram_ctrl: RTL and testbench
============================

# sram_ctrl

Parametrised asynchronous-SRAM controller between the internal CPU bus and the external SRAM pins. It replaces the fixed one-cycle read/write strobe with a sequenced access that has a configurable number of wait cycles, a write data-hold phase and a one-deep pending-request slot. It also provides a read-data valid pulse and a busy flag that the top level can fold into CPU READY. It sits beside the address decoder; the top level owns the tri-state buffer on the SRAM data pins.

## Interface
- ADDR_W, 20, address width.
- DATA_W, 8, data width.
- RD_WAIT, 1, extra cycles OE is held low beyond the first (0..15).
- WR_WAIT, 1, extra cycles WE is held low beyond the first (0..15).
- WR_HOLD, 1, cycles data stays driven after WE rises (0..3).

Ports:
- iClk  in  1  system clock (10 MHz domain).
- iRstN  in  1  reset; asynchronous, active low.
- iAddr  in  ADDR_W  CPU address.
- iData  in  DATA_W  CPU write data.
- iRd  in  1  memory read strobe, one cycle.
- iWr  in  1  memory write strobe, one cycle.
- iSel  in  1  decoder select for this device; strobes are ignored when low.
- iOvrClr  in  1  clears oOverrun.
- oData  out  DATA_W  latched read data.
- oValid  out  1  one-cycle pulse when oData is updated.
- oBusy  out  1  access in progress or pending.
- oOverrun  out  1  sticky flag: a request was dropped.
- oSramA  out  ADDR_W  registered SRAM address.
- oSramD  out  DATA_W  registered write data.
- iSramD  in  DATA_W  SRAM read data.
- oSramDir  out  1  1 = fpga->sram (drive), 0 = release.
- oSramOe, oSramWe, oSramCe1  out  1  active low.
- oSramCe2  out  1  active high.

## Operation
- Request = (iRd | iWr) & iSel, sampled on the rising edge of iClk. If iRd and iWr are both high, the write wins and the read is discarded.
- States:
  - IDLE: all strobes inactive.
  - RD: OE low, Dir 0.
  - WR: WE low, Dir 1.
  - WHOLD: WE high, Dir 1, oSramD held.
- IDLE + request -> RD or WR. oSramA and oSramD latch the address and data on that edge. The cycle counter loads RD_WAIT or WR_WAIT.
- RD: lasts RD_WAIT+1 cycles. On its final edge, iSramD is latched into oData, oValid pulses for the next cycle, and OE returns high.
- WR: lasts WR_WAIT+1 cycles, then goes to WHOLD for WR_HOLD cycles. When WR_HOLD=0, WHOLD is skipped and Dir drops with WE.
- Pending slot: a request that arrives while not IDLE is stored (address, data, rd/wr). When the current access ends, the pending request starts on the same edge with no IDLE cycle, and the slot is freed.
- A request that arrives while the slot is full is dropped and sets oOverrun. oOverrun clears only on iOvrClr; a set and a clear in the same cycle leave it set.
- oBusy = (state != IDLE) | pending valid. It is combinational from registers.
- Reset values: state IDLE, oSramOe=1, oSramWe=1, oSramDir=0, oValid=0, oBusy=0, oOverrun=0, oData=0, oSramA=0, oSramD=0, pending cleared.
- Reset asserted mid-access aborts immediately and asynchronously. Strobes go inactive with no hold phase. A read aborted this way produces no oValid.

## Timing
- Read latency from request edge to oValid high: RD_WAIT+2 cycles (3 at defaults).
- Write occupancy: 1+WR_WAIT+WR_HOLD cycles from the first WE-low cycle until the state machine can accept the next access.
- Throughput with back-to-back pending: one access per (RD_WAIT+1) or (WR_WAIT+1+WR_HOLD) cycles.
- oSramA and oSramD are stable for the entire strobe period and the hold period. OE and WE are never both low, and Dir is never 1 while OE is low.
- oSramA changes only on the edge that starts a new access.

## Configuration
- SRAM_CE_GATE_EN defined:
  - oSramCe1=0 and oSramCe2=1 only while in RD, WR or WHOLD.
  - Otherwise, including reset, Ce1=1 and Ce2=0 (power saving).
- Not defined: Ce1 is tied to 0 and Ce2 to 1 at all times.

## Structure
- Package sram_pkg holds:
  - the state encoding (IDLE, RD, WR, WHOLD);
  - the counter width constant CNT_W = 4;
  - the request-type encoding.
- Sub-module sram_req_slot: the one-deep pending-request register. It has load/take handshakes, outputs valid/addr/data/is_wr, and drives the overrun detect.

## Test plan
- Reset release, read 0x12345 with RD_WAIT=1 and the SRAM model returning 0xA5 -> OE low for exactly 2 cycles, oValid at request+3, oData=0xA5.
- Write 0x3C to 0x00010 with WR_WAIT=1, WR_HOLD=1 -> WE low for 2 cycles, Dir high for 3 cycles, oSramD=0x3C throughout, memory model holds 0x3C.
- Read issued on the cycle after a write -> pending slot used, RD starts on the edge the write ends, no IDLE gap, oBusy high throughout.
- Three requests on consecutive cycles -> third dropped, oOverrun=1; pulse iOvrClr -> oOverrun=0.
- iRd and iWr together with iSel=1 -> only a write occurs, no oValid. Any strobe with iSel=0 -> no access, oBusy stays 0.
- iRstN low during the second RD cycle -> OE=1 immediately, no oValid. With SRAM_CE_GATE_EN, Ce1=1 both after the access and during reset.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the asynchronous-SRAM controller.
// Holds the access-state encoding, the wait/hold counter width and the
// request-type encoding used by sram_ctrl and sram_req_slot.
package sram_pkg;

  // Width of the wait/hold down-counter; covers wait values 0..15.
  localparam int CNT_W = 4;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no access, all strobes inactive
    ST_RD    = 2'd1,  // OE low, data pins released
    ST_WR    = 2'd2,  // WE low, data pins driven
    ST_WHOLD = 2'd3   // WE high, data still driven
  } state_t;

  // Kind of a CPU request; a write wins when both strobes are high.
  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_t;

  // Convert an integer parameter into a counter load value.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/sram_req_slot.sv
// sram_req_slot: one-deep pending-request register for sram_ctrl.
// A push into an empty slot stores address, data and kind; a push while the
// slot is already full is refused and reported on o_drop (overrun detect).
// A take frees the slot on the same edge the owner starts the stored access.
module sram_req_slot
  import sram_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_take,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  req_kind_t         i_kind,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output req_kind_t         o_kind,
  output logic              o_drop
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  req_kind_t         r_kind;

  // The slot counts as full for the whole cycle it holds a request, even on
  // the edge that takes it, so a third request in that cycle is dropped.
  assign o_drop  = i_push & r_valid;
  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_kind  = r_kind;

  // Slot occupancy and payload capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_kind  <= REQ_RD;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_kind  <= i_kind;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequenced asynchronous-SRAM controller for the CPU bus.
// Reads hold OE low for RD_WAIT+1 cycles and return data with a one-cycle
// oValid pulse; writes hold WE low for WR_WAIT+1 cycles followed by WR_HOLD
// cycles of data hold. One request can wait in a pending slot and starts
// back-to-back with the running access; further requests set oOverrun.
// Optional feature macro: SRAM_CE_GATE_EN gates the chip enables so the
// SRAM is only selected while an access is running.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int WR_HOLD = 1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iRd,
  input  logic              iWr,
  input  logic              iSel,
  input  logic              iOvrClr,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOverrun,
  output logic [ADDR_W-1:0] oSramA,
  output logic [DATA_W-1:0] oSramD,
  input  logic [DATA_W-1:0] iSramD,
  output logic              oSramDir,
  output logic              oSramOe,
  output logic              oSramWe,
  output logic              oSramCe1,
  output logic              oSramCe2
);

  localparam logic [CNT_W-1:0] RD_LOAD   = cnt_load(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD   = cnt_load(WR_WAIT);
  localparam logic [CNT_W-1:0] HOLD_LOAD = cnt_load((WR_HOLD > 0) ? WR_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = cnt_load(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_sram_a;
  logic [DATA_W-1:0] r_sram_d;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;

  logic              w_req;
  req_kind_t         w_req_kind;
  logic              w_finish;
  logic              w_rd_done;
  logic              w_start;
  req_kind_t         w_start_kind;
  logic [ADDR_W-1:0] w_start_addr;
  logic [DATA_W-1:0] w_start_data;
  logic              w_take;
  logic              w_push;

  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_addr;
  logic [DATA_W-1:0] w_pend_data;
  req_kind_t         w_pend_kind;
  logic              w_drop;

  // A strobe counts only when the decoder selects us; a write beats a read.
  assign w_req      = (iRd | iWr) & iSel;
  assign w_req_kind = iWr ? REQ_WR : REQ_RD;

  sram_req_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .i_clk   (iClk),
    .i_rst_n (iRstN),
    .i_push  (w_push),
    .i_take  (w_take),
    .i_addr  (iAddr),
    .i_data  (iData),
    .i_kind  (w_req_kind),
    .o_valid (w_pend_valid),
    .o_addr  (w_pend_addr),
    .o_data  (w_pend_data),
    .o_kind  (w_pend_kind),
    .o_drop  (w_drop)
  );

  // Next-state, counter and access-start selection.
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_finish     = 1'b0;
    w_rd_done    = 1'b0;
    w_start      = 1'b0;
    w_start_kind = w_req_kind;
    w_start_addr = iAddr;
    w_start_data = iData;
    w_take       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req) w_start = 1'b1;
      end
      ST_RD: begin
        if (r_cnt == '0) begin
          w_rd_done = 1'b1;
          w_finish  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_WR: begin
        if (r_cnt == '0) begin
          if (WR_HOLD == 0) begin
            w_finish = 1'b1;
          end else begin
            w_state_nxt = ST_WHOLD;
            w_cnt_nxt   = HOLD_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_WHOLD: begin
        if (r_cnt == '0) w_finish = 1'b1;
        else             w_cnt_nxt = r_cnt - CNT_ONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // At the end of an access the pending request has priority; a fresh
    // request starts directly only when the slot is empty.
    if (w_finish) begin
      if (w_pend_valid) begin
        w_start      = 1'b1;
        w_take       = 1'b1;
        w_start_kind = w_pend_kind;
        w_start_addr = w_pend_addr;
        w_start_data = w_pend_data;
      end else if (w_req) begin
        w_start = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end

    if (w_start) begin
      w_state_nxt = (w_start_kind == REQ_WR) ? ST_WR : ST_RD;
      w_cnt_nxt   = (w_start_kind == REQ_WR) ? WR_LOAD : RD_LOAD;
    end
  end

  // Any request not started directly this edge is offered to the slot.
  assign w_push = w_req & ~(w_start & ~w_take);

  // Sequencer state and wait counter.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // SRAM address/data latch: changes only on the edge that starts an access.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_sram_a <= '0;
      r_sram_d <= '0;
    end else if (w_start) begin
      r_sram_a <= w_start_addr;
      r_sram_d <= w_start_data;
    end
  end

  // Read-data capture with a one-cycle valid pulse.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_done;
      if (w_rd_done) r_data <= iSramD;
    end
  end

  // Sticky overrun flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_overrun <= 1'b0;
    else        r_overrun <= w_drop | (r_overrun & ~iOvrClr);
  end

  // Strobes decode straight from the state register, so reset releases
  // them asynchronously and OE/WE can never be low together.
  assign oSramOe  = (r_state != ST_RD);
  assign oSramWe  = (r_state != ST_WR);
  assign oSramDir = (r_state == ST_WR) | (r_state == ST_WHOLD);
  assign oSramA   = r_sram_a;
  assign oSramD   = r_sram_d;
  assign oData    = r_data;
  assign oValid   = r_valid;
  assign oOverrun = r_overrun;
  assign oBusy    = (r_state != ST_IDLE) | w_pend_valid;

`ifdef SRAM_CE_GATE_EN
  // Chip selected only while an access runs; deselected in IDLE and reset.
  assign oSramCe1 = (r_state == ST_IDLE);
  assign oSramCe2 = (r_state != ST_IDLE);
`else
  // Chip permanently selected.
  assign oSramCe1 = 1'b0;
  assign oSramCe2 = 1'b1;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl at default parameters.
// A behavioural SRAM sits on the pins; a transaction-level reference model
// (access start cycle, elapsed cycles, pending entry) predicts every output.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 8;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;
  localparam int WR_HOLD = 1;
  localparam int RD_LEN  = RD_WAIT + 1;
  localparam int WR_LEN  = WR_WAIT + 1 + WR_HOLD;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic [ADDR_W-1:0] iAddr;
  logic [DATA_W-1:0] iData;
  logic              iRd, iWr, iSel, iOvrClr;
  logic [DATA_W-1:0] oData;
  logic              oValid, oBusy, oOverrun;
  logic [ADDR_W-1:0] oSramA;
  logic [DATA_W-1:0] oSramD;
  logic [DATA_W-1:0] iSramD;
  logic              oSramDir, oSramOe, oSramWe, oSramCe1, oSramCe2;

  int n_checks = 0;
  int n_errors = 0;

  sram_ctrl #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT), .WR_HOLD (WR_HOLD)
  ) dut (
    .iClk (iClk), .iRstN (iRstN), .iAddr (iAddr), .iData (iData),
    .iRd (iRd), .iWr (iWr), .iSel (iSel), .iOvrClr (iOvrClr),
    .oData (oData), .oValid (oValid), .oBusy (oBusy), .oOverrun (oOverrun),
    .oSramA (oSramA), .oSramD (oSramD), .iSramD (iSramD),
    .oSramDir (oSramDir), .oSramOe (oSramOe), .oSramWe (oSramWe),
    .oSramCe1 (oSramCe1), .oSramCe2 (oSramCe2)
  );

  always #50 iClk = ~iClk;

  // Behavioural SRAM (low 10 address bits) driven only by the pins.
  logic [7:0] sram_mem [0:1023];
  logic [7:0] ref_mem  [0:1023];
  always @(posedge iClk) if (iRstN && !oSramWe) sram_mem[oSramA[9:0]] <= oSramD;
  assign iSramD = (!oSramOe) ? sram_mem[oSramA[9:0]] : 8'h00;

  // Reference model state.
  bit         m_active, m_wr, p_valid, p_wr, m_valid, m_ovr;
  int         m_k;
  logic [19:0] m_addr, p_addr, m_last_a;
  logic [7:0]  m_wdata, p_data, m_last_d, m_rdata;
  bit         exp_oe, exp_we, exp_dir, exp_busy, exp_ce1, exp_ce2;

  function automatic void model_reset();
    m_active = 0; m_wr = 0; m_k = 0; p_valid = 0; p_wr = 0;
    m_valid = 0; m_ovr = 0; m_addr = '0; p_addr = '0; p_data = '0;
    m_wdata = '0; m_last_a = '0; m_last_d = '0; m_rdata = '0;
  endfunction

  function automatic void model_start(input bit wr, input logic [19:0] a, input logic [7:0] d);
    m_active = 1; m_wr = wr; m_k = 0; m_addr = a; m_wdata = d;
    m_last_a = a; m_last_d = d;
  endfunction

  // Advance the model across one rising edge using the inputs it samples.
  function automatic void model_edge();
    bit req, drop, ending;
    req  = (iRd | iWr) & iSel;
    drop = 0;
    ending = m_active && (m_k == (m_wr ? WR_LEN : RD_LEN) - 1);
    m_valid = 0;
    if (ending) begin
      if (!m_wr) begin m_valid = 1; m_rdata = ref_mem[m_addr[9:0]]; end
      else ref_mem[m_addr[9:0]] = m_wdata;
      m_active = 0;
      if (p_valid) begin
        model_start(p_wr, p_addr, p_data); p_valid = 0;
        if (req) drop = 1;
      end else if (req) model_start(iWr, iAddr, iData);
    end else if (m_active) begin
      m_k++;
      if (req) begin
        if (p_valid) drop = 1;
        else begin p_valid = 1; p_wr = iWr; p_addr = iAddr; p_data = iData; end
      end
    end else if (req) model_start(iWr, iAddr, iData);
    m_ovr = drop | (m_ovr & !iOvrClr);
  endfunction

  function automatic void model_outputs();
    exp_oe   = !(m_active && !m_wr);
    exp_we   = !(m_active && m_wr && m_k <= WR_WAIT);
    exp_dir  = m_active && m_wr;
    exp_busy = m_active || p_valid;
`ifdef SRAM_CE_GATE_EN
    exp_ce1 = !m_active; exp_ce2 = m_active;
`else
    exp_ce1 = 1'b0; exp_ce2 = 1'b1;
`endif
  endfunction

  // One clock: advance model at the edge, drive new inputs, return at negedge.
  task automatic cycle(input bit rd, input bit wr, input bit sel,
                       input logic [19:0] a, input logic [7:0] d, input bit clr);
    @(posedge iClk);
    model_edge();
    #1;
    iRd = rd; iWr = wr; iSel = sel; iAddr = a; iData = d; iOvrClr = clr;
    @(negedge iClk);
    model_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    iRstN = 0; iRd = 0; iWr = 0; iSel = 0; iOvrClr = 0; iAddr = '0; iData = '0;
    model_reset(); model_outputs();
    #120;
    n_checks++; if (oSramOe !== 1'b1) begin n_errors++; $display("FAIL reset_oe: got %b expected 1", oSramOe); end
    n_checks++; if (oSramWe !== 1'b1) begin n_errors++; $display("FAIL reset_we: got %b expected 1", oSramWe); end
    n_checks++; if (oSramDir !== 1'b0) begin n_errors++; $display("FAIL reset_dir: got %b expected 0", oSramDir); end
    n_checks++; if ({oValid, oBusy, oOverrun} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {oValid, oBusy, oOverrun}); end
    n_checks++; if ({oData, oSramA, oSramD} !== '0) begin n_errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", oData, oSramA, oSramD); end
    n_checks++; if ({oSramCe1, oSramCe2} !== {exp_ce1, exp_ce2}) begin n_errors++; $display("FAIL reset_ce: got %b%b expected %b%b", oSramCe1, oSramCe2, exp_ce1, exp_ce2); end
    @(negedge iClk); iRstN = 1;
  endtask

  task automatic test_read();
    int oe_cnt = 0, first_oe = -1, valid_at = -1, vcnt = 0, a_bad = 0;
    logic [7:0] vdata = '0;
    sram_mem[20'h12345 & 10'h3FF] = 8'hA5; ref_mem[20'h12345 & 10'h3FF] = 8'hA5;
    cycle(1, 0, 1, 20'h12345, 8'h00, 0);
    for (int c = 1; c <= 6; c++) begin
      idle(1);
      if (!oSramOe) begin oe_cnt++; if (first_oe < 0) first_oe = c; if (oSramA !== 20'h12345) a_bad++; end
      if (oValid) begin vcnt++; valid_at = c; vdata = oData; end
    end
    n_checks++; if (oe_cnt != RD_WAIT + 1) begin n_errors++; $display("FAIL read_oe_len: got %0d expected %0d", oe_cnt, RD_WAIT + 1); end
    n_checks++; if (first_oe != 1) begin n_errors++; $display("FAIL read_oe_start: got %0d expected 1", first_oe); end
    n_checks++; if (valid_at != RD_WAIT + 2 || vcnt != 1) begin n_errors++; $display("FAIL read_valid: got cycle %0d count %0d expected cycle %0d count 1", valid_at, vcnt, RD_WAIT + 2); end
    n_checks++; if (vdata !== 8'hA5) begin n_errors++; $display("FAIL read_data: got %h expected a5", vdata); end
    n_checks++; if (a_bad != 0) begin n_errors++; $display("FAIL read_addr: got %0d bad cycles expected 0", a_bad); end
  endtask

  task automatic test_write();
    int we_cnt = 0, dir_cnt = 0, d_bad = 0;
    cycle(0, 1, 1, 20'h00010, 8'h3C, 0);
    for (int c = 1; c <= 6; c++) begin
      idle(1);
      if (!oSramWe) we_cnt++;
      if (oSramDir) begin
        dir_cnt++;
        if (oSramD !== 8'h3C || oSramA !== 20'h00010) d_bad++;
      end
    end
    n_checks++; if (we_cnt != WR_WAIT + 1) begin n_errors++; $display("FAIL write_we_len: got %0d expected %0d", we_cnt, WR_WAIT + 1); end
    n_checks++; if (dir_cnt != WR_LEN) begin n_errors++; $display("FAIL write_dir_len: got %0d expected %0d", dir_cnt, WR_LEN); end
    n_checks++; if (d_bad != 0) begin n_errors++; $display("FAIL write_hold_data: got %0d bad cycles expected 0", d_bad); end
    n_checks++; if (sram_mem[10'h010] !== 8'h3C) begin n_errors++; $display("FAIL write_mem: got %h expected 3c", sram_mem[10'h010]); end
  endtask

  task automatic test_back_to_back();
    int last_dir = -1, first_oe = -1, last_oe = -1, valid_at = -1;
    bit busy_seen[0:9];
    logic [7:0] vdata = '0;
    int gap = 0;
    cycle(0, 1, 1, 20'h00020, 8'h5A, 0);
    busy_seen[0] = oBusy;
    cycle(1, 0, 1, 20'h00020, 8'h00, 0);
    busy_seen[1] = oBusy;
    for (int c = 2; c <= 9; c++) begin
      idle(1);
      busy_seen[c] = oBusy;
      if (oSramDir) last_dir = c;
      if (!oSramOe) begin if (first_oe < 0) first_oe = c; last_oe = c; end
      if (oValid) begin valid_at = c; vdata = oData; end
    end
    for (int c = 1; c <= 9; c++) if (c <= last_oe && !busy_seen[c]) gap++;
    n_checks++; if (first_oe != 1 + WR_LEN || first_oe != last_dir + 1) begin n_errors++; $display("FAIL b2b_no_gap: got oe start %0d dir end %0d expected %0d/%0d", first_oe, last_dir, 1 + WR_LEN, WR_LEN); end
    n_checks++; if (gap != 0) begin n_errors++; $display("FAIL b2b_busy: got %0d idle cycles expected 0", gap); end
    n_checks++; if (valid_at != 1 + WR_LEN + RD_LEN || vdata !== 8'h5A) begin n_errors++; $display("FAIL b2b_read: got cycle %0d data %h expected cycle %0d data 5a", valid_at, vdata, 1 + WR_LEN + RD_LEN); end
  endtask

  task automatic test_overrun();
    int vcnt = 0;
    cycle(1, 0, 1, 20'h00101, 8'h00, 0);
    cycle(1, 0, 1, 20'h00102, 8'h00, 0);
    cycle(1, 0, 1, 20'h00103, 8'h00, 0);
    n_checks++; if (oOverrun !== 1'b0) begin n_errors++; $display("FAIL ovr_early: got %b expected 0", oOverrun); end
    for (int c = 3; c <= 10; c++) begin idle(1); if (oValid) vcnt++; end
    n_checks++; if (oOverrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b expected 1", oOverrun); end
    n_checks++; if (vcnt != 2) begin n_errors++; $display("FAIL ovr_dropped: got %0d reads expected 2", vcnt); end
    cycle(0, 0, 0, '0, '0, 1);
    idle(1);
    n_checks++; if (oOverrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear: got %b expected 0", oOverrun); end
  endtask

  task automatic test_sel_and_priority();
    int vcnt = 0, we_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    cycle(1, 1, 1, 20'h00030, 8'h77, 0);
    for (int c = 1; c <= 6; c++) begin
      idle(1);
      if (oValid) vcnt++;
      if (!oSramWe) we_cnt++;
      if (!oSramOe) oe_cnt++;
    end
    n_checks++; if (vcnt != 0 || oe_cnt != 0) begin n_errors++; $display("FAIL rdwr_no_read: got valid %0d oe %0d expected 0/0", vcnt, oe_cnt); end
    n_checks++; if (we_cnt != WR_WAIT + 1 || sram_mem[10'h030] !== 8'h77) begin n_errors++; $display("FAIL rdwr_write: got we %0d mem %h expected %0d/77", we_cnt, sram_mem[10'h030], WR_WAIT + 1); end
    for (int c = 0; c < 8; c++) begin
      cycle(c[0], c[1], 0, 20'(c * 7), 8'(c), 0);
      if (oBusy || !oSramOe || !oSramWe) busy_cnt++;
    end
    idle(2);
    if (oBusy || !oSramOe || !oSramWe) busy_cnt++;
    n_checks++; if (busy_cnt != 0) begin n_errors++; $display("FAIL unselected: got %0d active cycles expected 0", busy_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            20'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
      n_checks++; if (oSramOe !== exp_oe) begin n_errors++; $display("FAIL rnd_oe c%0d: got %b expected %b", c, oSramOe, exp_oe); end
      n_checks++; if (oSramWe !== exp_we) begin n_errors++; $display("FAIL rnd_we c%0d: got %b expected %b", c, oSramWe, exp_we); end
      n_checks++; if (oSramDir !== exp_dir) begin n_errors++; $display("FAIL rnd_dir c%0d: got %b expected %b", c, oSramDir, exp_dir); end
      n_checks++; if (oBusy !== exp_busy) begin n_errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, oBusy, exp_busy); end
      n_checks++; if (oValid !== m_valid) begin n_errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, oValid, m_valid); end
      n_checks++; if (oData !== m_rdata) begin n_errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c, oData, m_rdata); end
      n_checks++; if (oOverrun !== m_ovr) begin n_errors++; $display("FAIL rnd_ovr c%0d: got %b expected %b", c, oOverrun, m_ovr); end
      n_checks++; if (oSramA !== m_last_a) begin n_errors++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, oSramA, m_last_a); end
      n_checks++; if (oSramD !== m_last_d) begin n_errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, oSramD, m_last_d); end
      n_checks++; if ({oSramCe1, oSramCe2} !== {exp_ce1, exp_ce2}) begin n_errors++; $display("FAIL rnd_ce c%0d: got %b%b expected %b%b", c, oSramCe1, oSramCe2, exp_ce1, exp_ce2); end
    end
    idle(12);
  endtask

  task automatic test_reset_abort();
    int vcnt = 0;
    cycle(1, 0, 1, 20'h00044, 8'h00, 0);
    idle(2);
    n_checks++; if (oSramOe !== 1'b0) begin n_errors++; $display("FAIL abort_setup: got oe %b expected 0", oSramOe); end
    #10 iRstN = 0;
    #1;
    model_reset(); model_outputs();
    n_checks++; if ({oSramOe, oSramWe, oSramDir, oBusy} !== 4'b1100) begin n_errors++; $display("FAIL abort_strobes: got %b expected 1100", {oSramOe, oSramWe, oSramDir, oBusy}); end
    n_checks++; if ({oSramCe1, oSramCe2} !== {exp_ce1, exp_ce2}) begin n_errors++; $display("FAIL abort_ce: got %b%b expected %b%b", oSramCe1, oSramCe2, exp_ce1, exp_ce2); end
    idle(1);
    iRstN = 1;
    for (int c = 0; c < 5; c++) begin idle(1); if (oValid) vcnt++; end
    n_checks++; if (vcnt != 0 || oData !== 8'h00) begin n_errors++; $display("FAIL abort_no_valid: got %0d pulses data %h expected 0/00", vcnt, oData); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 8'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_overrun();
    test_sel_and_priority();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
